// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable Mealy serial pattern detector (1..PAT_W bits, overlap/flush modes).
// Define SEQDET_MATCH_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_detector_param #(
    parameter int               PAT_W     = 8,
    parameter int               CNT_W     = 16,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(8'b0000_0101),
    parameter int               RESET_LEN = 3,
    parameter bit               RESET_OVL = 1'b1,
    localparam int              LEN_W     = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             detected,
    output logic             detected_q,
    output logic [CNT_W-1:0] match_count
);
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             det_q;
    logic [PAT_W-1:0] window, mask;
    logic             len_ok, fill_ok;

    always_comb begin
        window  = {hist_q, in_bit};
        mask    = ~({PAT_W{1'b1}} << len_q);
        len_ok  = (len_q != '0) && (len_q <= LEN_W'(PAT_W));
        fill_ok = (fill_q + LEN_W'(1)) >= len_q;
        // Only the low L bits of the window/pattern take part in the compare
        detected = reset_n & in_valid & ~cfg_load & len_ok & fill_ok
                 & (((window ^ pat_q) & mask) == '0);
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = window[PAT_W-2:0];
            fill_d = (detected && !ovl_q) ? '0
                   : (fill_q == LEN_W'(PAT_W - 1)) ? fill_q : fill_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= RESET_PAT;
            len_q  <= LEN_W'(RESET_LEN);
            ovl_q  <= RESET_OVL;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            det_q  <= detected;
        end
    end

    assign detected_q = det_q;

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb
        cnt_d = cnt_clr ? CNT_W'(detected)
              : (detected && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign match_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of seq_detector_param; a CNT_W=2 copy shares the stimulus for saturation.
module tb_seq_detector_param;
`ifdef SEQDET_MATCH_COUNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif
    logic       clk = 1'b0, reset_n = 1'b0;
    logic       in_valid = 1'b0, in_bit = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       det0, dq0, det1, dq1;
    logic [15:0] mc0;
    logic [1:0]  mc1;
    int vecs = 0, errs = 0, c0 = 0, c1 = 0;
    logic pdet = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .detected(det0), .detected_q(dq0), .match_count(mc0)
    );

    seq_detector_param #(.CNT_W(2)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .detected(det1), .detected_q(dq1), .match_count(mc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: registered outputs from the previous cycle are checked first
    task automatic cyc(input logic ld, input logic v, input logic b, input logic clr, input logic e);
        @(negedge clk);
        chk("detected_q", {31'd0, dq0}, {31'd0, pdet});
        chk("detected_q_w2", {31'd0, dq1}, {31'd0, pdet});
        chk("match_count", {16'd0, mc0}, CE ? c0 : 0);
        chk("match_count_w2", {30'd0, mc1}, CE ? c1 : 0);
        in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr;
        #1;
        chk("detected", {31'd0, det0}, {31'd0, e});
        chk("detected_w2", {31'd0, det1}, {31'd0, e});
        if (clr) begin
            c0 = e ? 1 : 0;
            c1 = e ? 1 : 0;
        end else if (e) begin
            c0++;
            c1 = (c1 == 3) ? 3 : c1 + 1;
        end
        pdet = e;
    endtask

    task automatic sb(input logic b, input logic e);
        cyc(1'b0, 1'b1, b, 1'b0, e);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic b);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        cyc(1'b1, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        in_valid = 1'b1; in_bit = 1'b1;
        #1;
        chk("rst_detected", {31'd0, det0}, 32'd0);
        chk("rst_detected_q", {31'd0, dq0}, 32'd0);
        chk("rst_count", {16'd0, mc0}, 32'd0);
        chk("rst_count_w2", {30'd0, mc1}, 32'd0);
        c0 = 0; c1 = 0; pdet = 1'b0;
        in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // default 101 overlapping
        sb(1, 0); sb(0, 0); sb(1, 1); sb(0, 0); sb(1, 1);
        // 1101, non-overlapping: flush blocks the match on bit 7
        load(8'b1101, 4'd4, 1'b0, 1'b1);
        sb(1, 0); sb(1, 0); sb(0, 0); sb(1, 1); sb(1, 0); sb(0, 0); sb(1, 0);
        // in_valid gap holds state
        load(8'b101, 4'd3, 1'b1, 1'b0);
        sb(1, 0); sb(0, 0);
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
        sb(1, 1);
        // clear, then four matches saturate the 2-bit counter
        cyc(0, 0, 0, 1, 0);
        load(8'b101, 4'd3, 1'b1, 1'b0);
        sb(1, 0); sb(0, 0); sb(1, 1); sb(0, 0); sb(1, 1);
        sb(0, 0); sb(1, 1); sb(0, 0); sb(1, 1);
        sb(0, 0);
        cyc(0, 1, 1, 1, 1);
        // reset mid-pattern
        sb(1, 0); sb(0, 0);
        do_reset();
        sb(1, 0); sb(0, 0); sb(1, 1);
        // illegal lengths never detect
        load(8'b101, 4'd0, 1'b1, 1'b0);
        sb(1, 0); sb(0, 0); sb(1, 0); sb(1, 0); sb(0, 0); sb(1, 0);
        load(8'b101, 4'd9, 1'b1, 1'b0);
        sb(1, 0); sb(0, 0); sb(1, 0); sb(0, 0); sb(1, 0);
        // cfg_load on a would-be matching bit discards it
        load(8'b101, 4'd3, 1'b1, 1'b0);
        sb(1, 0); sb(0, 0);
        load(8'b101, 4'd3, 1'b1, 1'b1);
        sb(0, 0); sb(1, 0); sb(0, 0); sb(1, 1);
        // full-width pattern
        load(8'hA5, 4'd8, 1'b1, 1'b0);
        sb(1, 0); sb(0, 0); sb(1, 0); sb(0, 0); sb(0, 0); sb(1, 0); sb(0, 0); sb(1, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
